// File: rtl/sg_scan_array_if.sv
// sg_scan_array_if: program-word channel and fired-tag channel of the spike-generator array
interface sg_scan_array_if #(
  parameter int N_SG_gens   = 8,
  parameter int N_SG_period = 16,
  parameter int N_SG_tag    = 11
);
  logic [N_SG_gens-1:0]   prog_gen_idx;
  logic [N_SG_period-1:0] prog_period;
  logic [N_SG_period-1:0] prog_ticks;
  logic [N_SG_tag-1:0]    prog_tag;
  logic                   prog_v;
  logic                   prog_a;
  logic [N_SG_tag-1:0]    out_tag;
  logic                   out_v;
  logic                   out_a;
  modport master (
    output prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_v, out_a,
    input  prog_a, out_tag, out_v
  );
  modport slave (
    input  prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_v, out_a,
    output prog_a, out_tag, out_v
  );
endinterface

// File: rtl/sg_scan_array.sv
// sg_scan_array: per-time-unit scan of spike generators, emitting tags of those whose countdown expires
module sg_scan_array #(
  parameter int N_SG_gens   = 8,
  parameter int N_SG_period = 16,
  parameter int N_SG_tag    = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  sg_scan_array_if.slave          bus,
  input  logic [N_SG_gens-1:0]    gens_used,
  input  logic [2**N_SG_gens-1:0] gens_en,
  input  logic                    time_unit,
  output logic                    busy,
  output logic [7:0]              overrun_ct
);
  localparam int W = 2*N_SG_period + N_SG_tag;
  typedef enum logic [1:0] {IDLE, READ, UPDATE, EMIT} state_t;
  state_t                 state;
  logic [W-1:0]           mem [2**N_SG_gens];
  logic [W-1:0]           rdata, wdata;
  logic [N_SG_gens-1:0]   cur, used_q, waddr;
  logic [N_SG_period-1:0] r_period, r_ticks;
  logic [N_SG_tag-1:0]    r_tag;
  logic                   pending, we, active, fire, last, step;
  assign {r_period, r_ticks, r_tag} = rdata;
  always_comb begin
    active = gens_en[cur] && r_period != '0;
    fire   = active && r_ticks == '0;
    last   = cur == used_q - N_SG_gens'(1);
    step   = (state == UPDATE && !fire) || (state == EMIT && bus.out_a);
    we     = (bus.prog_a && bus.prog_v) || (state == UPDATE && active);
    waddr  = state == IDLE ? bus.prog_gen_idx : cur;
    wdata  = state == IDLE ? {bus.prog_period, bus.prog_ticks, bus.prog_tag}
                           : {r_period, (fire ? r_period : r_ticks) - N_SG_period'(1), r_tag};
  end
  // Memory is deliberately unreset so programmed generators survive a reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[cur];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur         <= '0;
      used_q      <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      overrun_ct  <= '0;
      bus.prog_a  <= 1'b1;
      bus.out_v   <= 1'b0;
      bus.out_tag <= '0;
    end else begin
      if (time_unit && state != IDLE) begin
        if (!pending) pending <= 1'b1;
        else if (overrun_ct != 8'hFF) overrun_ct <= overrun_ct + 8'd1;
      end
      case (state)
        IDLE: if ((time_unit || pending) && gens_used != '0) begin
          used_q     <= gens_used;
          cur        <= '0;
          pending    <= 1'b0;
          state      <= READ;
          busy       <= 1'b1;
          bus.prog_a <= 1'b0;
        end
        READ: state <= UPDATE;
        UPDATE: if (fire) begin
          bus.out_v   <= 1'b1;
          bus.out_tag <= r_tag;
          state       <= EMIT;
        end
        EMIT: if (bus.out_a) bus.out_v <= 1'b0;
      endcase
      if (step) begin
        if (last) begin
          state      <= IDLE;
          busy       <= 1'b0;
          bus.prog_a <= 1'b1;
        end else begin
          cur   <= cur + N_SG_gens'(1);
          state <= READ;
        end
      end
    end
  end
endmodule

// File: tb/tb_sg_scan_array.sv
// tb_sg_scan_array: randomized scan passes checked against a per-generator countdown model
module tb_sg_scan_array;
  logic         clk = 0;
  logic         reset = 0;
  logic [7:0]   gens_used = 0;
  logic [255:0] gens_en = '0;
  logic         time_unit = 0;
  logic         busy;
  logic [7:0]   overrun_ct;
  logic         hold = 0;
  int n_chk = 0, n_err = 0;
  int m_per[256], m_tk[256], m_tag[256];
  int exp_q[$], got[$];
  sg_scan_array_if bus ();
  sg_scan_array dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .gens_used(gens_used),
    .gens_en(gens_en), .time_unit(time_unit), .busy(busy), .overrun_ct(overrun_ct)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    bus.out_a = !hold && ($urandom_range(0, 3) != 0);
  end
  always @(negedge clk) if (reset && bus.out_v && bus.out_a) got.push_back(int'(bus.out_tag));
  task automatic chk(input string tag, input longint got_v, input longint exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got_v, exp_v);
    end
  endtask
  // One time unit of the reference: every active generator counts down, firing at zero.
  task automatic model_pass;
    for (int i = 0; i < int'(gens_used); i++)
      if (gens_en[i] && m_per[i] != 0) begin
        if (m_tk[i] == 0) begin
          exp_q.push_back(m_tag[i]);
          m_tk[i] = m_per[i] - 1;
        end else m_tk[i]--;
      end
  endtask
  task automatic prog(input int g, input int p, input int k, input int t);
    int n = 0;
    bus.prog_gen_idx = 8'(g);
    bus.prog_period  = 16'(p);
    bus.prog_ticks   = 16'(k);
    bus.prog_tag     = 11'(t);
    bus.prog_v       = 1;
    do begin @(negedge clk); n++; end while (!bus.prog_a && n < 200);
    chk("prog_accept", n < 200, 1);
    @(posedge clk); #1 bus.prog_v = 0;
    m_per[g] = p; m_tk[g] = k; m_tag[g] = t;
  endtask
  task automatic pulse;
    @(posedge clk); #1 time_unit = 1;
    @(posedge clk); #1 time_unit = 0;
  endtask
  task automatic wait_idle;
    int quiet = 0, n = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
      n++;
    end
    chk("idle_timeout", n < 3000, 1);
  endtask
  task automatic wait_v(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_v && n < 100);
  endtask
  task automatic compare_got(input string tag);
    chk({tag, "_ntags"}, got.size(), exp_q.size());
    foreach (exp_q[i]) chk({tag, "_tag"}, i < got.size() ? got[i] : -1, exp_q[i]);
  endtask
  task automatic run_pass(input string tag);
    exp_q.delete();
    model_pass();
    got.delete();
    pulse();
    wait_idle();
    compare_got(tag);
  endtask
  initial begin
    int n, stable, bsy;
    bus.prog_v = 0; bus.prog_gen_idx = 0; bus.prog_period = 0; bus.prog_ticks = 0; bus.prog_tag = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_v", bus.out_v, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prog_a", bus.prog_a, 1);
    chk("rst_overrun", overrun_ct, 0);
    @(posedge clk); #1 reset = 1;
    // single generator cadence and first-fire latency
    prog(3, 4, 0, 'h155);
    gens_used = 4; gens_en = '0; gens_en[3] = 1;
    exp_q.delete(); model_pass(); got.delete();
    pulse();
    wait_v(n);
    chk("latency", n, 9);
    wait_idle();
    compare_got("single1");
    for (int p = 2; p <= 8; p++) begin
      run_pass("single");
      repeat (10) @(posedge clk);
    end
    // order and disable rules
    prog(0, 1, 0, 'h001);
    prog(1, 0, 0, 'h3AA);
    prog(2, 1, 0, 'h002);
    gens_used = 3; gens_en = '0; gens_en[2:0] = 3'b111;
    repeat (3) run_pass("order");
    gens_en[2] = 0;
    repeat (2) run_pass("disable");
    // randomized programs, enables and scan lengths
    for (int g = 0; g < 16; g++)
      prog(g, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 2047));
    for (int r = 0; r < 20; r++) begin
      if (r % 4 == 0) begin
        gens_en = '0;
        gens_en[15:0] = 16'($urandom);
        gens_used = 8'($urandom_range(1, 16));
      end
      run_pass("rand");
    end
    // backpressure with a pending pass and one overrun
    prog(0, 1, 0, 'h011);
    prog(1, 1, 0, 'h022);
    gens_used = 2; gens_en = '0; gens_en[1:0] = 2'b11;
    hold = 1;
    repeat (2) @(posedge clk);
    exp_q.delete(); model_pass(); model_pass(); got.delete();
    pulse();
    wait_v(n);
    chk("bp_first_v", bus.out_v, 1);
    chk("bp_first_tag", bus.out_tag, 'h011);
    stable = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1 time_unit = (i == 5 || i == 10);
      @(negedge clk);
      if (bus.out_v && bus.out_tag == 11'h011 && busy) stable++;
    end
    time_unit = 0;
    chk("bp_stable", stable, 30);
    chk("bp_overrun", overrun_ct, 1);
    hold = 0;
    wait_idle();
    compare_got("bp");
    // gens_used == 0 ignores the pulse
    gens_used = 0;
    got.delete();
    pulse();
    bsy = 0;
    repeat (10) begin @(negedge clk); bsy |= busy; end
    chk("idle_busy", bsy, 0);
    chk("idle_tags", got.size(), 0);
    // program request during a pass waits for IDLE
    gens_used = 4; gens_en = '0; gens_en[3:0] = 4'hF;
    prog(2, 3, 5, 'h100);
    prog(3, 2, 1, 'h200);
    exp_q.delete(); model_pass(); got.delete();
    pulse();
    bus.prog_gen_idx = 2; bus.prog_period = 2; bus.prog_ticks = 0; bus.prog_tag = 'h0AB;
    bus.prog_v = 1;
    @(negedge clk);
    chk("prog_a_busy", bus.prog_a, 0);
    n = 0;
    while (!bus.prog_a && n < 500) begin @(negedge clk); n++; end
    chk("prog_a_idle_busy", busy, 0);
    chk("prog_a_wait", n > 3, 1);
    @(posedge clk); #1 bus.prog_v = 0;
    m_per[2] = 2; m_tk[2] = 0; m_tag[2] = 'h0AB;
    wait_idle();
    compare_got("prog_busy");
    run_pass("prog_after");
    // same-cycle program and pulse
    gens_used = 1; gens_en = '0; gens_en[0] = 1;
    @(posedge clk); #1;
    bus.prog_gen_idx = 0; bus.prog_period = 1; bus.prog_ticks = 0; bus.prog_tag = 'h7FF;
    bus.prog_v = 1; time_unit = 1;
    @(posedge clk); #1 bus.prog_v = 0; time_unit = 0;
    m_per[0] = 1; m_tk[0] = 0; m_tag[0] = 'h7FF;
    exp_q.delete(); model_pass(); got.delete();
    wait_idle();
    compare_got("same_cycle");
    // reset mid-pass keeps memory, abandons the emission
    prog(0, 2, 0, 'h5A5);
    hold = 1;
    repeat (2) @(posedge clk);
    exp_q.delete(); model_pass();
    pulse();
    wait_v(n);
    chk("mid_v", bus.out_v, 1);
    #2 reset = 0;
    #1;
    chk("mid_rst_v", bus.out_v, 0);
    chk("mid_rst_overrun", overrun_ct, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_prog_a", bus.prog_a, 1);
    @(posedge clk); #1 reset = 1; hold = 0;
    run_pass("post_rst1");
    run_pass("post_rst2");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
